// File: rtl/seq_signed_div.sv
`timescale 1ns/1ps
// seq_signed_div: multi-cycle signed divider using restoring shift-subtract
// on operand magnitudes, followed by a sign fix-up cycle.
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   valid_i / ready_o         operand handshake (ready_o high only in IDLE)
//   dividend_i, divisor_i     signed two's-complement operands
//   valid_o / ready_i         result handshake (result held until ready_i)
//   quotient_o, remainder_o   signed results, truncation toward zero
//   div_by_zero_o, overflow_o special-case flags for the held result
module seq_signed_div #(
    parameter int unsigned DATA_IN_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DATA_IN_W-1:0] dividend_i,
    input  logic [DATA_IN_W-1:0] divisor_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DATA_IN_W-1:0] quotient_o,
    output logic [DATA_IN_W-1:0] remainder_o,
    output logic                 div_by_zero_o,
    output logic                 overflow_o
);

    localparam int unsigned W     = DATA_IN_W;
    localparam int unsigned CNT_W = $clog2(DATA_IN_W) + 1;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W:0]       rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     dmag_q, dmag_d;
    logic [W-1:0]     dvd_q, dvd_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dsr_neg_q, dsr_neg_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [W-1:0]     quot_out_q, quot_out_d;
    logic [W-1:0]     rem_out_q, rem_out_d;
    logic             dbz_out_q, dbz_out_d;
    logic             ovf_out_q, ovf_out_d;

    // Restoring step datapath: shift in next dividend bit, trial-subtract.
    logic [W:0] shifted;
    logic [W:0] diff;
    logic       fits;
    logic [W-1:0] abs_dvd;
    logic [W-1:0] abs_dsr;

    always_comb begin
        shifted = (W+1)'({rem_q, quo_q[W-1]});
        diff    = shifted - {1'b0, dmag_q};
        fits    = (shifted >= {1'b0, dmag_q});
        abs_dvd = dividend_i[W-1] ? (~dividend_i + W'(1)) : dividend_i;
        abs_dsr = divisor_i[W-1]  ? (~divisor_i  + W'(1)) : divisor_i;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dmag_d     = dmag_q;
        dvd_d      = dvd_q;
        dvd_neg_d  = dvd_neg_q;
        dsr_neg_d  = dsr_neg_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;
        ready_d    = ready_q;
        valid_d    = valid_q;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        dbz_out_d  = dbz_out_q;
        ovf_out_d  = ovf_out_q;

        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    dvd_d     = dividend_i;
                    dvd_neg_d = dividend_i[W-1];
                    dsr_neg_d = divisor_i[W-1];
                    quo_d     = abs_dvd;
                    dmag_d    = abs_dsr;
                    rem_d     = '0;
                    cnt_d     = CNT_W'(W - 1);
                    dbz_d     = (divisor_i == '0);
                    ovf_d     = (dividend_i == MIN_NEG) && (divisor_i == '1);
                    ready_d   = 1'b0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                // The counter runs W-1 down to 0 (one quotient bit each);
                // the underflow cycle that follows fixes total latency at W+2.
                if (cnt_q[CNT_W-1]) begin
                    state_d = FIX;
                end else begin
                    rem_d   = fits ? diff : shifted;
                    quo_d   = {quo_q[W-2:0], fits};
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                valid_d   = 1'b1;
                dbz_out_d = dbz_q;
                ovf_out_d = ovf_q;
                if (dbz_q) begin
                    quot_out_d = '1;
                    rem_out_d  = dvd_q;
                end else if (ovf_q) begin
                    quot_out_d = MIN_NEG;
                    rem_out_d  = '0;
                end else begin
                    quot_out_d = (dvd_neg_q ^ dsr_neg_q) ? (~quo_q + W'(1)) : quo_q;
                    rem_out_d  = dvd_neg_q ? (~rem_q[W-1:0] + W'(1)) : rem_q[W-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dmag_q     <= '0;
            dvd_q      <= '0;
            dvd_neg_q  <= 1'b0;
            dsr_neg_q  <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            dbz_out_q  <= 1'b0;
            ovf_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dmag_q     <= dmag_d;
            dvd_q      <= dvd_d;
            dvd_neg_q  <= dvd_neg_d;
            dsr_neg_q  <= dsr_neg_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
            dbz_out_q  <= dbz_out_d;
            ovf_out_q  <= ovf_out_d;
        end
    end

    assign ready_o       = ready_q;
    assign valid_o       = valid_q;
    assign quotient_o    = quot_out_q;
    assign remainder_o   = rem_out_q;
    assign div_by_zero_o = dbz_out_q;
    assign overflow_o    = ovf_out_q;

endmodule

// File: tb/tb_seq_signed_div.sv
`timescale 1ns/1ps
// tb_seq_signed_div: directed vectors with hand-computed results, plus a
// plain-arithmetic reference model checked on every cycle valid_o is high.
module tb_seq_signed_div;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         div_by_zero_o;
    logic         overflow_o;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_a, m_b;
    bit           exp_pending = 1'b0;

    seq_signed_div #(.DATA_IN_W(W)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .quotient_o   (quotient_o),
        .remainder_o  (remainder_o),
        .div_by_zero_o(div_by_zero_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division (SV truncates toward zero).
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov);
        int ia, ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (ib == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (ia == -(1 << (W - 1)) && ib == -1) begin
            q  = a;
            r  = '0;
            ov = 1'b1;
        end else begin
            q = W'(ia / ib);
            r = W'(ia % ib);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready_o), 32'd1);
        check({tag, "_valid"}, 32'(valid_o), 32'd0);
        check({tag, "_quot"},  32'(quotient_o), 32'd0);
        check({tag, "_rem"},   32'(remainder_o), 32'd0);
        check({tag, "_dbz"},   32'(div_by_zero_o), 32'd0);
        check({tag, "_ovf"},   32'(overflow_o), 32'd0);
    endtask

    // Every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (rst_n && valid_o) begin
            if (!exp_pending) begin
                check("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                logic [W-1:0] q, r;
                logic dz, ov;
                model(m_a, m_b, q, r, dz, ov);
                check("mon_quot",  32'(quotient_o), 32'(q));
                check("mon_rem",   32'(remainder_o), 32'(r));
                check("mon_dbz",   32'(div_by_zero_o), 32'(dz));
                check("mon_ovf",   32'(overflow_o), 32'(ov));
                check("mon_ready_low", 32'(ready_o), 32'd0);
            end
        end
    end

    // Accept one operation and wait (bounded) for its result.
    task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit lit, input logic [W-1:0] eq, input logic [W-1:0] er,
                                  input logic ed, input logic eo);
        int n;
        check("ready_before_accept", 32'(ready_o), 32'd1);
        valid_i    = 1'b1;
        dividend_i = a;
        divisor_i  = b;
        @(posedge clk);
        #1;
        valid_i     = 1'b0;
        m_a         = a;
        m_b         = b;
        exp_pending = 1'b1;
        n = 0;
        while (!valid_o && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'd18);
        if (lit) begin
            check("lit_quot", 32'(quotient_o), 32'(eq));
            check("lit_rem",  32'(remainder_o), 32'(er));
            check("lit_dbz",  32'(div_by_zero_o), 32'(ed));
            check("lit_ovf",  32'(overflow_o), 32'(eo));
        end
    endtask

    // Consume with ready_i=1 already high: one edge back to IDLE.
    task automatic consume();
        @(posedge clk);
        #1;
        exp_pending = 1'b0;
        check("consumed_valid", 32'(valid_o), 32'd0);
        check("consumed_ready", 32'(ready_o), 32'd1);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit lit, input logic [W-1:0] eq, input logic [W-1:0] er,
                      input logic ed, input logic eo);
        start_and_wait(a, b, lit, eq, er, ed, eo);
        consume();
    endtask

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         dz, ov;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [W-1:0] hq, hr;
        logic         hd, ho;

        vecs.push_back('{16'd100,   16'd7,      16'd14,     16'd2,      1'b0, 1'b0});
        vecs.push_back('{16'hFF9C,  16'd7,      16'hFFF2,   16'hFFFE,   1'b0, 1'b0});
        vecs.push_back('{16'd100,   16'hFFF9,   16'hFFF2,   16'd2,      1'b0, 1'b0});
        vecs.push_back('{16'hFF9C,  16'hFFF9,   16'd14,     16'hFFFE,   1'b0, 1'b0});
        vecs.push_back('{16'h8000,  16'hFFFF,   16'h8000,   16'd0,      1'b0, 1'b1});
        vecs.push_back('{16'd1234,  16'd0,      16'hFFFF,   16'h04D2,   1'b1, 1'b0});
        vecs.push_back('{16'hFFFB,  16'd0,      16'hFFFF,   16'hFFFB,   1'b1, 1'b0});
        vecs.push_back('{16'h7FFF,  16'd1,      16'h7FFF,   16'd0,      1'b0, 1'b0});
        vecs.push_back('{16'h8000,  16'd1,      16'h8000,   16'd0,      1'b0, 1'b0});
        vecs.push_back('{16'h8000,  16'h7FFF,   16'hFFFF,   16'hFFFF,   1'b0, 1'b0});
        vecs.push_back('{16'd7,     16'd100,    16'd0,      16'd7,      1'b0, 1'b0});
        vecs.push_back('{16'd0,     16'hFFFD,   16'd0,      16'd0,      1'b0, 1'b0});
        vecs.push_back('{16'h8000,  16'd2,      16'hC000,   16'd0,      1'b0, 1'b0});
        vecs.push_back('{16'h7FFF,  16'h8000,   16'd0,      16'h7FFF,   1'b0, 1'b0});

        rst_n      = 1'b0;
        valid_i    = 1'b0;
        ready_i    = 1'b1;
        dividend_i = '0;
        divisor_i  = '0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First accept on the first edge after release.
        foreach (vecs[i])
            op(vecs[i].a, vecs[i].b, 1'b1, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);

        // Backpressure: hold result for 5 cycles, ignore a stray valid_i.
        ready_i = 1'b0;
        start_and_wait(16'hFF9C, 16'hFFF9, 1'b1, 16'd14, 16'hFFFE, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                valid_i    = 1'b1;
                dividend_i = 16'd555;
                divisor_i  = 16'd5;
            end else begin
                valid_i = 1'b0;
            end
            @(posedge clk);
            #1;
            check("bp_quot",  32'(quotient_o), 32'd14);
            check("bp_rem",   32'(remainder_o), 32'hFFFE);
            check("bp_valid", 32'(valid_o), 32'd1);
            check("bp_ready", 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        consume();
        op(16'd1000, 16'd3, 1'b1, 16'd333, 16'd1, 1'b0, 1'b0);

        // Reset abort in the middle of CALC.
        valid_i    = 1'b1;
        dividend_i = 16'd999;
        divisor_i  = 16'd4;
        @(posedge clk);
        #1;
        valid_i     = 1'b0;
        m_a         = 16'd999;
        m_b         = 16'd4;
        exp_pending = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        rst_n       = 1'b0;
        exp_pending = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        op(16'd100, 16'd7, 1'b1, 16'd14, 16'd2, 1'b0, 1'b0);

        // Random operands checked against the model only.
        for (int k = 0; k < 20; k++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (k % 7 == 3) ? W'(0) : W'($urandom);
            model(ra, rb, hq, hr, hd, ho);
            op(ra, rb, 1'b0, hq, hr, hd, ho);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
